// File: rtl/wb_commit_pkg.sv
// Shared types for the writeback/commit stage: queue entry layout, exception
// cause indices (bit 0 = highest priority) and FSM state encodings.
`ifndef WB_COMMIT_PKG_SV
`define WB_COMMIT_PKG_SV

// Full queued word: the fixed entry fields plus an EXC_W-wide cause vector.
`define WB_ENTRY_W(EXCW) (119 + (EXCW))

package wb_commit_pkg;

  // The cause vector is carried next to this struct because its width is a parameter.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic        ertn;
    logic        refetch;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        csr_re;
    logic [13:0] csr_num;
  } wb_entry_t;

  localparam int ENTRY_BASE_W = $bits(wb_entry_t);

  localparam int ECODE_INT        = 0;
  localparam int ECODE_ADEF       = 1;
  localparam int ECODE_TLBR_FETCH = 2;
  localparam int ECODE_PIF        = 3;
  localparam int ECODE_PPI_FETCH  = 4;
  localparam int ECODE_ALE        = 5;
  localparam int ECODE_ADEM       = 6;
  localparam int ECODE_TLBR_MEM   = 7;
  localparam int ECODE_PIL        = 8;
  localparam int ECODE_PIS        = 9;
  localparam int ECODE_PME        = 10;
  localparam int ECODE_PPI_MEM    = 11;
  localparam int ECODE_SYS        = 12;
  localparam int ECODE_BRK        = 13;
  localparam int ECODE_INE        = 14;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_CSR_WAIT = 2'd2
  } wb_state_t;

endpackage

`endif

// File: rtl/wb_commit_if.sv
// Memory-stage to writeback-stage bus with its allowin backpressure.
interface wb_commit_if #(parameter int EXC_W = 16);
  logic             ms2ws_valid;
  logic             ws_allowin;
  logic [31:0]      ms2ws_pc;
  logic [31:0]      ms2ws_vaddr;
  logic [EXC_W-1:0] ms2ws_exc;
  logic             ms2ws_ertn;
  logic             ms2ws_refetch;
  logic             ms2ws_rf_we;
  logic [4:0]       ms2ws_rf_waddr;
  logic [31:0]      ms2ws_rf_wdata;
  logic             ms2ws_csr_re;
  logic [13:0]      ms2ws_csr_num;

  modport master (output ms2ws_valid, ms2ws_pc, ms2ws_vaddr, ms2ws_exc, ms2ws_ertn,
                  ms2ws_refetch, ms2ws_rf_we, ms2ws_rf_waddr, ms2ws_rf_wdata,
                  ms2ws_csr_re, ms2ws_csr_num,
                  input  ws_allowin);
  modport slave  (input  ms2ws_valid, ms2ws_pc, ms2ws_vaddr, ms2ws_exc, ms2ws_ertn,
                  ms2ws_refetch, ms2ws_rf_we, ms2ws_rf_waddr, ms2ws_rf_wdata,
                  ms2ws_csr_re, ms2ws_csr_num,
                  output ws_allowin);
endinterface

// File: rtl/wb_queue.sv
// In-order commit queue: synchronous FIFO with flush; DEPTH must be a power of two.
module wb_queue #(
  parameter  int DEPTH = 2,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic [W-1:0]  o_head
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_din;
  end

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: retires the queue head in order, handles CSR read
// handshakes, exceptions and flushes. WB_PERF_CNT_EN builds the retire counter.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int EXC_W    = 16,
  parameter int ECAUSE_W = $clog2(EXC_W)
) (
  input  logic                clk,
  input  logic                resetn,
  wb_commit_if.slave          ms,
  output logic                csr_rd_req,
  output logic [13:0]         csr_rd_num,
  input  logic                csr_rd_ack,
  input  logic [31:0]         csr_rvalue,
  output logic                ws_rf_we,
  output logic [4:0]          ws_rf_waddr,
  output logic [31:0]         ws_rf_wdata,
  output logic                wb_ex,
  output logic [ECAUSE_W-1:0] wb_ecause,
  output logic [31:0]         wb_pc,
  output logic [31:0]         wb_vaddr,
  output logic                ertn_flush,
  output logic                wb_refetch_flush,
  output logic [31:0]         debug_wb_pc,
  output logic [3:0]          debug_wb_rf_we,
  output logic [4:0]          debug_wb_rf_wnum,
  output logic [31:0]         debug_wb_rf_wdata,
  output logic [63:0]         retire_cnt
);
  localparam int QW = `WB_ENTRY_W(EXC_W);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_state_t r_state, w_state_nxt;
  wb_entry_t w_in, w_head;
  logic [EXC_W-1:0] w_head_exc;
  logic [QW-1:0] w_head_bus;
  logic [CW-1:0] w_count, w_cnt_nxt;
  logic [ECAUSE_W-1:0] w_ecause_enc;
  logic [31:0] w_rf_data;
  logic w_full, w_empty, w_push, w_commit, w_flush, w_exc_any, w_csr_pend;

  always_comb begin
    w_in = '{pc: ms.ms2ws_pc, vaddr: ms.ms2ws_vaddr, ertn: ms.ms2ws_ertn,
             refetch: ms.ms2ws_refetch, rf_we: ms.ms2ws_rf_we,
             waddr: ms.ms2ws_rf_waddr, wdata: ms.ms2ws_rf_wdata,
             csr_re: ms.ms2ws_csr_re, csr_num: ms.ms2ws_csr_num};
  end

  wb_queue #(.DEPTH(DEPTH), .W(QW)) u_queue (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_din   ({ms.ms2ws_exc, w_in}),
    .i_pop   (w_commit),
    .i_flush (w_flush),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head_bus)
  );
  assign w_head_exc = w_head_bus[QW-1 -: EXC_W];
  assign w_head     = w_head_bus[ENTRY_BASE_W-1:0];

  // Allowin looks only at registered occupancy; a same-cycle pop does not help.
  assign ms.ws_allowin = ~w_full;
  assign w_push        = ms.ms2ws_valid & ~w_full & ~w_flush;

  assign w_exc_any  = |w_head_exc;
  assign w_csr_pend = w_head.csr_re & ~w_exc_any;
  assign w_commit   = ((r_state == ST_COMMIT) & ~w_csr_pend) |
                      ((r_state == ST_CSR_WAIT) & csr_rd_ack);
  assign w_flush    = wb_ex | ertn_flush | wb_refetch_flush;
  assign w_cnt_nxt  = w_count + CW'(w_push) - CW'(w_commit);

  // Lowest set bit wins: scan from the top so the last hit is the smallest index.
  always_comb begin
    w_ecause_enc = '0;
    for (int i = EXC_W - 1; i >= 0; i--)
      if (w_head_exc[i]) w_ecause_enc = ECAUSE_W'(i);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_EMPTY;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY:    if (w_push) w_state_nxt = ST_COMMIT;
      ST_COMMIT:   if (w_flush)       w_state_nxt = ST_EMPTY;
                   else if (w_commit) w_state_nxt = (w_cnt_nxt != '0) ? ST_COMMIT : ST_EMPTY;
                   else               w_state_nxt = ST_CSR_WAIT;
      ST_CSR_WAIT: if (w_flush)       w_state_nxt = ST_EMPTY;
                   else if (w_commit) w_state_nxt = (w_cnt_nxt != '0) ? ST_COMMIT : ST_EMPTY;
      default:     w_state_nxt = ST_EMPTY;
    endcase
  end

  assign csr_rd_req = (r_state == ST_CSR_WAIT);
  assign csr_rd_num = csr_rd_req ? w_head.csr_num : '0;

  assign wb_ex            = w_commit & w_exc_any;
  assign wb_ecause        = wb_ex ? w_ecause_enc : '0;
  assign ertn_flush       = w_commit & ~w_exc_any & w_head.ertn;
  assign wb_refetch_flush = w_commit & ~w_exc_any & ~w_head.ertn & w_head.refetch;

  assign w_rf_data   = w_head.csr_re ? csr_rvalue : w_head.wdata;
  assign ws_rf_we    = w_commit & w_head.rf_we & ~wb_ex & ~ertn_flush;
  assign ws_rf_waddr = w_empty ? '0 : w_head.waddr;
  assign ws_rf_wdata = w_empty ? '0 : w_rf_data;
  assign wb_pc       = w_empty ? '0 : w_head.pc;
  assign wb_vaddr    = w_empty ? '0 : w_head.vaddr;

  assign debug_wb_pc       = w_commit ? w_head.pc : '0;
  assign debug_wb_rf_we    = {4{ws_rf_we}};
  assign debug_wb_rf_wnum  = w_commit ? w_head.waddr : '0;
  assign debug_wb_rf_wdata = w_commit ? w_rf_data : '0;

`ifdef WB_PERF_CNT_EN
  logic [63:0] r_retire_cnt;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_retire_cnt <= '0;
    else         r_retire_cnt <= r_retire_cnt + 64'(w_commit);
  end
  assign retire_cnt = r_retire_cnt;
`else
  assign retire_cnt = '0;
`endif
endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: stream, CSR handshake, exception priority,
// fill/backpressure, flush collisions and async reset mid CSR wait.
module tb_wb_commit;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        csr_rd_req, csr_rd_ack;
  logic [13:0] csr_rd_num;
  logic [31:0] csr_rvalue;
  logic        ws_rf_we, wb_ex, ertn_flush, wb_refetch_flush;
  logic [4:0]  ws_rf_waddr, debug_wb_rf_wnum;
  logic [31:0] ws_rf_wdata, wb_pc, wb_vaddr, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  wb_ecause, debug_wb_rf_we;
  logic [63:0] retire_cnt, exp_ret;
  int n_cmp = 0;
  int n_err = 0;

  wb_commit_if #(.EXC_W(16)) ms();

  wb_commit #(.DEPTH(2), .EXC_W(16)) dut (
    .clk(clk), .resetn(resetn), .ms(ms),
    .csr_rd_req(csr_rd_req), .csr_rd_num(csr_rd_num), .csr_rd_ack(csr_rd_ack),
    .csr_rvalue(csr_rvalue), .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr),
    .ws_rf_wdata(ws_rf_wdata), .wb_ex(wb_ex), .wb_ecause(wb_ecause), .wb_pc(wb_pc),
    .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .wb_refetch_flush(wb_refetch_flush),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ms.ms2ws_valid = 1'b0; ms.ms2ws_pc = '0; ms.ms2ws_vaddr = '0; ms.ms2ws_exc = '0;
    ms.ms2ws_ertn = 1'b0; ms.ms2ws_refetch = 1'b0; ms.ms2ws_rf_we = 1'b0;
    ms.ms2ws_rf_waddr = '0; ms.ms2ws_rf_wdata = '0; ms.ms2ws_csr_re = 1'b0;
    ms.ms2ws_csr_num = '0;
  endtask

  task automatic put(input logic [31:0] pc, input logic [31:0] va, input logic [15:0] exc,
                     input logic er, input logic rf, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic cre, input logic [13:0] cnum);
    ms.ms2ws_valid = 1'b1; ms.ms2ws_pc = pc; ms.ms2ws_vaddr = va; ms.ms2ws_exc = exc;
    ms.ms2ws_ertn = er; ms.ms2ws_refetch = rf; ms.ms2ws_rf_we = we;
    ms.ms2ws_rf_waddr = wa; ms.ms2ws_rf_wdata = wd; ms.ms2ws_csr_re = cre;
    ms.ms2ws_csr_num = cnum;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(); csr_rd_ack = 1'b0; csr_rvalue = '0;
    #1 resetn = 1'b0;
    #2;
    chk("rst_allowin", ms.ws_allowin, 1);
    chk("rst_rf_we", ws_rf_we, 0);
    chk("rst_dbg_pc", debug_wb_pc, 0);
    chk("rst_csr_req", csr_rd_req, 0);
    chk("rst_wdata", ws_rf_wdata, 0);
    chk("rst_retire", retire_cnt, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // back-to-back stream of four plain writes
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i < 4) put(32'h1c000000 + 32'(4*i), '0, '0, 0, 0, 1, 5'(i+1), 32'h100 + 32'(i), 0, '0);
      else idle();
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_pc", debug_wb_pc, 32'h1c000000 + 32'(4*(i-1)));
        chk("b2b_we", debug_wb_rf_we, 4'hf);
        chk("b2b_wnum", ws_rf_waddr, 5'(i));
        chk("b2b_wdata", debug_wb_rf_wdata, 32'h100 + 32'(i-1));
      end
    end
    cyc(); @(negedge clk);
    chk("b2b_drain_pc", debug_wb_pc, 0);

    // CSR read with three wait cycles
    cyc(); put(32'h1c000010, '0, '0, 0, 0, 1, 5'd5, 32'h0, 1, 14'h006);
    cyc(); idle(); @(negedge clk);
    chk("csr_bubble_req", csr_rd_req, 0);
    chk("csr_bubble_we", ws_rf_we, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk);
      chk("csr_wait_req", csr_rd_req, 1);
      chk("csr_wait_num", csr_rd_num, 14'h006);
      chk("csr_wait_dbg", debug_wb_pc, 0);
    end
    cyc(); csr_rd_ack = 1'b1; csr_rvalue = 32'hdeadbeef; @(negedge clk);
    chk("csr_ack_wdata", ws_rf_wdata, 32'hdeadbeef);
    chk("csr_ack_we", ws_rf_we, 1);
    chk("csr_ack_pc", debug_wb_pc, 32'h1c000010);
    cyc(); csr_rd_ack = 1'b0; csr_rvalue = '0; @(negedge clk);
    chk("csr_after_req", csr_rd_req, 0);
    chk("csr_after_dbg", debug_wb_pc, 0);

    // fill behind a CSR read, then an exception head with a dropped follower
    cyc(); put(32'h1c000020, '0, '0, 0, 0, 1, 5'd7, 32'h0, 1, 14'h00c);
    @(negedge clk); chk("fill_allow0", ms.ws_allowin, 1);
    cyc(); put(32'h1c000024, 32'h0000bad0, 16'h1020, 0, 0, 1, 5'd8, 32'h88, 0, '0);
    @(negedge clk); chk("fill_bubble_req", csr_rd_req, 0);
    cyc(); idle(); @(negedge clk);
    chk("fill_full", ms.ws_allowin, 0);
    chk("fill_req", csr_rd_req, 1);
    chk("fill_num", csr_rd_num, 14'h00c);
    cyc(); csr_rd_ack = 1'b1; csr_rvalue = 32'h12345678; @(negedge clk);
    chk("fill_ack_wdata", ws_rf_wdata, 32'h12345678);
    chk("fill_ack_pc", debug_wb_pc, 32'h1c000020);
    chk("fill_ack_allow", ms.ws_allowin, 0);
    cyc(); csr_rd_ack = 1'b0; csr_rvalue = '0;
    put(32'h1c000028, '0, '0, 0, 0, 1, 5'd9, 32'h99, 0, '0);
    @(negedge clk);
    chk("exc_allow", ms.ws_allowin, 1);
    chk("exc_ex", wb_ex, 1);
    chk("exc_cause", wb_ecause, 5);
    chk("exc_rf_we", ws_rf_we, 0);
    chk("exc_dbg_we", debug_wb_rf_we, 0);
    chk("exc_pc", wb_pc, 32'h1c000024);
    chk("exc_vaddr", wb_vaddr, 32'h0000bad0);
    cyc(); idle(); @(negedge clk);
    chk("exc_flushed_pc", debug_wb_pc, 0);
    chk("exc_flushed_ex", wb_ex, 0);
    cyc(); @(negedge clk);
    chk("exc_dropped_pc", debug_wb_pc, 0);

    // ertn commit colliding with an incoming instruction
    cyc(); put(32'h1c000030, '0, '0, 1, 0, 1, 5'd3, 32'h33, 0, '0);
    cyc(); put(32'h1c000034, '0, '0, 0, 0, 1, 5'd4, 32'h44, 0, '0);
    @(negedge clk);
    chk("ertn_flush", ertn_flush, 1);
    chk("ertn_rf_we", ws_rf_we, 0);
    chk("ertn_refetch", wb_refetch_flush, 0);
    cyc(); idle(); @(negedge clk);
    chk("ertn_after_flush", ertn_flush, 0);
    chk("ertn_dropped_pc", debug_wb_pc, 0);
    cyc(); @(negedge clk);
    chk("ertn_dropped_pc2", debug_wb_pc, 0);

    // refetch keeps the register write
    cyc(); put(32'h1c000040, '0, '0, 0, 1, 1, 5'd9, 32'h99, 0, '0);
    cyc(); idle(); @(negedge clk);
    chk("refetch_flush", wb_refetch_flush, 1);
    chk("refetch_rf_we", ws_rf_we, 1);
    chk("refetch_dbg_we", debug_wb_rf_we, 4'hf);
    chk("refetch_wnum", debug_wb_rf_wnum, 9);
    chk("refetch_ex", wb_ex, 0);
    cyc(); @(negedge clk);
    chk("refetch_after_pc", debug_wb_pc, 0);

`ifdef WB_PERF_CNT_EN
    exp_ret = 64'd9;
`else
    exp_ret = 64'd0;
`endif
    chk("retire_cnt", retire_cnt, exp_ret);

    // async reset while waiting on a CSR ack
    cyc(); put(32'h1c000050, '0, '0, 0, 0, 1, 5'd2, 32'h0, 1, 14'h040);
    cyc(); idle();
    cyc(); @(negedge clk);
    chk("arst_pre_req", csr_rd_req, 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_req", csr_rd_req, 0);
    chk("arst_num", csr_rd_num, 0);
    chk("arst_retire", retire_cnt, 0);
    chk("arst_allow", ms.ws_allowin, 1);
    cyc(); resetn = 1'b1; csr_rd_ack = 1'b1; csr_rvalue = 32'hcafef00d;
    @(negedge clk);
    chk("late_ack_we", ws_rf_we, 0);
    chk("late_ack_pc", debug_wb_pc, 0);
    chk("late_ack_req", csr_rd_req, 0);
    chk("late_ack_retire", retire_cnt, 0);
    csr_rd_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_commit.md
# wb_commit

Parametrised writeback/commit stage. Buffers up to DEPTH completed instructions from the memory stage in an in-order queue and retires one per cycle. For CSR reads it uses a request/acknowledge handshake, which allows multi-cycle CSR access. It resolves exceptions with a priority-indexed cause vector, raises exception, ertn and refetch flushes, and drives register-file writeback, ID-stage forwarding and the debug trace ports.

## Interface
Parameters:
- DEPTH, 2: queue entries (power of two, ≥2)
- EXC_W, 16: exception cause vector width; bit 0 is highest priority
- ECAUSE_W, $clog2(EXC_W): width of the encoded cause index

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- ms2ws_valid  in  1  memory stage presents an instruction
- ws_allowin  out  1  queue not full; enqueue occurs when ms2ws_valid & ws_allowin
- ms2ws_pc  in  32  instruction PC
- ms2ws_vaddr  in  32  faulting/access virtual address
- ms2ws_exc  in  EXC_W  exception cause vector
- ms2ws_ertn, ms2ws_refetch  in  1 each  ertn / refetch-after-commit flags
- ms2ws_rf_we  in  1  register-file write enable
- ms2ws_rf_waddr  in  5  register-file write address
- ms2ws_rf_wdata  in  32  register-file write data
- ms2ws_csr_re  in  1  result comes from a CSR read
- ms2ws_csr_num  in  14  CSR number for the read
- csr_rd_req  out  1  CSR read request
- csr_rd_num  out  14  CSR number being requested
- csr_rd_ack  in  1  CSR read acknowledge
- csr_rvalue  in  32  CSR read data, valid with ack
- ws_rf_we  out  1  register-file write enable (also forwarded to ID)
- ws_rf_waddr  out  5  register-file write address
- ws_rf_wdata  out  32  register-file write data
- wb_ex  out  1  exception taken at commit
- wb_ecause  out  ECAUSE_W  encoded exception cause
- wb_pc  out  32  committing PC
- wb_vaddr  out  32  committing virtual address
- ertn_flush, wb_refetch_flush  out  1 each  flush requests
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_we  out  4  trace write enable
- debug_wb_rf_wnum  out  5  trace write register number
- debug_wb_rf_wdata  out  32  trace write data
- retire_cnt  out  64  retired-instruction count

## Operation
- The queue is in order. Only the head entry is processed.
- FSM states:
  - EMPTY: no head entry.
  - COMMIT: head present, no CSR read pending.
  - CSR_WAIT: head has csr_re and is waiting for the acknowledge.
- EMPTY→COMMIT when the queue becomes non-empty.
- A head with csr_re=1 and no exception enters CSR_WAIT:
  - csr_rd_req=1 and csr_rd_num=head csr_num, held stable until ack.
  - The ack cycle commits the head with ws_rf_wdata=csr_rvalue.
  - csr_rd_ack is ignored when no request is outstanding.
- Commit cycle, where the head retires and pops:
  - exc≠0: wb_ex=1, wb_ecause=index of lowest set bit, no RF write, no CSR request.
  - Otherwise, ertn=1: ertn_flush=1.
  - Otherwise, refetch=1: wb_refetch_flush=1; the RF write still occurs.
  - ws_rf_we=head rf_we & ~wb_ex & ~ertn_flush.
  - ws_rf_waddr and ws_rf_wdata are always driven from the head; data is csr_rvalue when csr_re.
- wb_pc, wb_vaddr and the debug_* outputs follow the head.
  - debug_wb_rf_we={4{ws_rf_we}}.
  - The debug outputs are gated to 0 when no commit occurs that cycle.
- Flush (wb_ex | ertn_flush | wb_refetch_flush):
  - Next edge: queue emptied, FSM→EMPTY.
  - An enqueue in the same cycle is dropped.
- Enqueue and pop in the same cycle: occupancy is unchanged and pointers wrap modulo DEPTH.
- ws_allowin = ~full, computed from registered occupancy. It does not look ahead to a same-cycle pop.

## Timing
- Instruction enqueued at edge t is at the earliest committed in cycle t+1. All commit outputs are combinational from the head and the ack.
- CSR read latency: commit occurs in the cycle csr_rd_ack=1. The minimum is a 0-wait ack in the first CSR_WAIT cycle.
- Throughput: 1 instruction/cycle without CSR reads.
- Reset (asynchronous assert, synchronous deassert by the system):
  - Queue empty, FSM EMPTY, retire_cnt=0.
  - Every output is 0 except ws_allowin=1.
- Reset during CSR_WAIT: csr_rd_req drops immediately. A late ack is ignored.
- Full queue: ws_allowin=0 until a pop has been registered.

## Configuration
- WB_PERF_CNT_EN defined: retire_cnt increments by 1 on every commit cycle, including exception/ertn/refetch commits. It wraps at 2^64.
- WB_PERF_CNT_EN undefined: retire_cnt is tied to 0 and no counter flops are built.

## Structure
- Shared package/header holds:
  - The queue entry layout (pc, vaddr, exc, ertn, refetch, rf_we, waddr, wdata, csr_re, csr_num) and its bus width macro.
  - Exception cause index constants (INT, ADEF, TLBR_FETCH, PIF, PPI_FETCH, ALE, ADEM, TLBR_MEM, PIL, PIS, PME, PPI_MEM, SYS, BRK, INE) in priority order.
  - FSM state encodings.
- Sub-module wb_queue: a synchronous FIFO with flush, the asynchronous active-low reset, and full/empty/head outputs. Commit, FSM and cause encoding stay in wb_commit.

## Test plan
- Back-to-back stream: enqueue 4 non-CSR instructions with pc 0x1c000000..0x1c00000c and rf_we=1 → 4 consecutive commit cycles with matching debug_wb_pc, debug_wb_rf_we=4'hf.
- CSR read: head csr_re=1, csr_num=0x006, ack after 3 cycles with csr_rvalue=0xdeadbeef → csr_rd_req high for 3 cycles, then commit with ws_rf_wdata=0xdeadbeef.
- Exception priority: exc bits 5 and 12 set, rf_we=1 → wb_ex=1, wb_ecause=5, ws_rf_we=0, queue flushed next cycle, a second queued entry is never committed.
- Fill: hold commit off via a pending CSR read with DEPTH=2 and 2 entries queued → ws_allowin=0. After the ack, ws_allowin=1 on the following cycle.
- Flush collision: ertn commit in the same cycle as ms2ws_valid=1 → ertn_flush=1, incoming entry dropped, FSM EMPTY next cycle.
- Async reset mid CSR_WAIT → csr_rd_req=0 without a clock edge. With WB_PERF_CNT_EN, retire_cnt=0 afterwards.
